// File: rtl/id_ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
// id_ex_operand_stage_if : ID, forwarding and EX-side signals of the stage
// Revision: 1.0
// ============================================================================
interface id_ex_operand_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_rR1;
    logic [AW-1:0] id_rR2;
    logic          id_use1;
    logic          id_use2;
    logic [DW-1:0] rf_rD1;
    logic [DW-1:0] rf_rD2;
    logic [AW-1:0] id_wR;
    logic          id_we;
    logic          id_is_load;
    logic [DW-1:0] id_imm;
    logic          ex_ready;
    logic          flush;
    logic [AW-1:0] exf_wR;
    logic          exf_we;
    logic          exf_load;
    logic [DW-1:0] exf_wD;
    logic [AW-1:0] memf_wR;
    logic          memf_we;
    logic [DW-1:0] memf_wD;
    logic [AW-1:0] wbf_wR;
    logic          wbf_we;
    logic [DW-1:0] wbf_wD;
    logic          ex_valid;
    logic [DW-1:0] ex_op1;
    logic [DW-1:0] ex_op2;
    logic [DW-1:0] ex_imm;
    logic [AW-1:0] ex_wR;
    logic          ex_we;
    logic          ex_is_load;
    logic          lu_stall;

    modport master (
        output id_valid, id_rR1, id_rR2, id_use1, id_use2, rf_rD1, rf_rD2,
               id_wR, id_we, id_is_load, id_imm, ex_ready, flush,
               exf_wR, exf_we, exf_load, exf_wD, memf_wR, memf_we, memf_wD,
               wbf_wR, wbf_we, wbf_wD,
        input  id_ready, ex_valid, ex_op1, ex_op2, ex_imm, ex_wR, ex_we,
               ex_is_load, lu_stall
    );

    modport slave (
        input  id_valid, id_rR1, id_rR2, id_use1, id_use2, rf_rD1, rf_rD2,
               id_wR, id_we, id_is_load, id_imm, ex_ready, flush,
               exf_wR, exf_we, exf_load, exf_wD, memf_wR, memf_we, memf_wD,
               wbf_wR, wbf_we, wbf_wD,
        output id_ready, ex_valid, ex_op1, ex_op2, ex_imm, ex_wR, ex_we,
               ex_is_load, lu_stall
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// id_ex_operand_stage : ID->EX operand capture with forwarding and load-use
// Revision: 1.0
// ============================================================================
module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  wire                    clk,
    input  wire                    rst,
    id_ex_operand_stage_if.slave   bus
);
    logic [AW-1:0] w_rr   [2];
    logic          w_use  [2];
    logic [DW-1:0] w_rf   [2];
    logic [DW-1:0] w_op   [2];
    logic          w_adv;
    logic          w_lu_stall;

    logic          r_ex_valid;
    logic [DW-1:0] r_ex_op1;
    logic [DW-1:0] r_ex_op2;
    logic [DW-1:0] r_ex_imm;
    logic [AW-1:0] r_ex_wR;
    logic          r_ex_we;
    logic          r_ex_is_load;

    assign w_rr[0]  = bus.id_rR1;
    assign w_rr[1]  = bus.id_rR2;
    assign w_use[0] = bus.id_use1;
    assign w_use[1] = bus.id_use2;
    assign w_rf[0]  = bus.rf_rD1;
    assign w_rf[1]  = bus.rf_rD2;

    // Newest producer wins; a load still in EX has no data yet and is skipped.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_op[n] = w_rf[n];
            if (w_use[n]) begin
                if (w_rr[n] == '0)
                    w_op[n] = '0;
                else if (bus.exf_we && !bus.exf_load && bus.exf_wR == w_rr[n])
                    w_op[n] = bus.exf_wD;
                else if (bus.memf_we && bus.memf_wR == w_rr[n])
                    w_op[n] = bus.memf_wD;
                else if (bus.wbf_we && bus.wbf_wR == w_rr[n])
                    w_op[n] = bus.wbf_wD;
            end
        end
    end

    assign w_lu_stall = bus.id_valid && bus.exf_we && bus.exf_load &&
                        (bus.exf_wR != '0) &&
                        ((bus.id_use1 && bus.exf_wR == bus.id_rR1) ||
                         (bus.id_use2 && bus.exf_wR == bus.id_rR2));
    assign w_adv      = bus.ex_ready || !r_ex_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_op1     <= '0;
            r_ex_op2     <= '0;
            r_ex_imm     <= '0;
            r_ex_wR      <= '0;
            r_ex_we      <= 1'b0;
            r_ex_is_load <= 1'b0;
        end else if (bus.flush || (w_adv && (w_lu_stall || !bus.id_valid))) begin
            r_ex_valid   <= 1'b0;
            r_ex_we      <= 1'b0;
            r_ex_is_load <= 1'b0;
        end else if (w_adv) begin
            r_ex_valid   <= 1'b1;
            r_ex_op1     <= w_op[0];
            r_ex_op2     <= w_op[1];
            r_ex_imm     <= bus.id_imm;
            r_ex_wR      <= bus.id_wR;
            r_ex_we      <= bus.id_we;
            r_ex_is_load <= bus.id_is_load;
        end
    end

    assign bus.id_ready   = w_adv && !w_lu_stall;
    assign bus.lu_stall   = w_lu_stall;
    assign bus.ex_valid   = r_ex_valid;
    assign bus.ex_op1     = r_ex_op1;
    assign bus.ex_op2     = r_ex_op2;
    assign bus.ex_imm     = r_ex_imm;
    assign bus.ex_wR      = r_ex_wR;
    assign bus.ex_we      = r_ex_we;
    assign bus.ex_is_load = r_ex_is_load;
endmodule
`default_nettype wire
